// File: rtl/add_long_arbiter.sv
// add_long_arbiter
//   Shares one limb-serial long adder among NREQ requesters using round-robin
//   arbitration. It captures the winner's operands, restarts the adder, waits
//   for the adder's finish level, then returns the L-limb sum together with a
//   one-cycle done pulse to the winner. A sticky error flag records any
//   operation that the timeout counter had to abort.
//
// Ports
//   ck          clock
//   rst         asynchronous reset, active-low
//   req         per-requester request level
//   req_a/req_b per-requester operands, packed [NREQ-1:0][L-1:0][WIDTH-1:0]
//   gnt         one-hot grant, held from grant until done
//   done        one-cycle completion pulse to the granted requester
//   res         result, valid in the done cycle, held until the next done
//   busy        high in LOAD/RUN/DONE
//   err         sticky timeout flag
//   add_a/add_b captured operands driven to the adder
//   add_rst     adder restart, active-high
//   add_finish  adder finish level
//   add_c       adder sum (limb 0 least significant)
module add_long_arbiter #(
  parameter int WIDTH   = 16,
  parameter int L       = 4,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                                  ck,
  input  logic                                  rst,
  input  logic [NREQ-1:0]                       req,
  input  logic [NREQ-1:0][L-1:0][WIDTH-1:0]     req_a,
  input  logic [NREQ-1:0][L-1:0][WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]                       gnt,
  output logic [NREQ-1:0]                       done,
  output logic [L-1:0][WIDTH-1:0]               res,
  output logic                                  busy,
  output logic                                  err,
  output logic [L-1:0][WIDTH-1:0]               add_a,
  output logic [L-1:0][WIDTH-1:0]               add_b,
  output logic                                  add_rst,
  input  logic                                  add_finish,
  input  logic [L-1:0][WIDTH-1:0]               add_c
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [NREQ-1:0]          gnt_q, gnt_d;
  logic [PW-1:0]            win_q, win_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [L-1:0][WIDTH-1:0]  add_a_q, add_a_d;
  logic [L-1:0][WIDTH-1:0]  add_b_q, add_b_d;
  logic [L-1:0][WIDTH-1:0]  res_q, res_d;
  logic                     err_q, err_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  // Round-robin pick: first set request at or above the pointer, wrapping.
  logic [PW-1:0] pick_idx;
  logic          pick_found;
  int            cand;

  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!pick_found && req[PW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gnt_d   = NREQ'(1) << pick_idx;
          win_d   = pick_idx;
          // Operands are frozen here; the requester may change them afterwards.
          add_a_d = req_a[pick_idx];
          add_b_d = req_b[pick_idx];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Finish wins over timeout when both land in the same cycle.
        if (add_finish) begin
          res_d   = add_c;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          res_d   = add_c;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // Move priority past the requester just served.
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign done    = (state_q == S_DONE) ? gnt_q : '0;
  assign res     = res_q;
  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  // The adder is held in restart while idle and during the load cycle.
  assign add_rst = (state_q == S_IDLE) || (state_q == S_LOAD);

endmodule

// File: doc/add_long_arbiter.md
Name: add_long_arbiter

Overview:
- Shares one limb-serial long adder (L limbs of WIDTH bits, base MAX, carry-serial, restart on active-high `rst`, level `finish`) among NREQ requesters in the pi datapath.
- Round-robin arbitration; captures the winner's operands, restarts the adder, waits for finish, then returns the L-limb sum with a one-cycle done pulse.
- Adds a sticky timeout error for a hung adder.

Parameters:
WIDTH, 16, limb width in bits
L, 4, limbs per long number
NREQ, 3, number of requesters (2..8)
TIMEOUT, 64, max RUN cycles before abort (must exceed L+2)

Ports:
ck  in  1  clock
rst  in  1  reset, asynchronous, active-low
req  in  NREQ  per-requester request level
req_a  in  NREQ*L*WIDTH  operand A per requester, packed [NREQ-1:0][L-1:0][WIDTH-1:0]
req_b  in  NREQ*L*WIDTH  operand B per requester, same packing
gnt  out  NREQ  one-hot grant, held from grant until done
done  out  NREQ  one-cycle completion pulse to the granted requester
res  out  L*WIDTH  result; valid in the done cycle, held until the next done
busy  out  1  high in LOAD/RUN/DONE
err  out  1  sticky timeout flag
add_a  out  L*WIDTH  adder operand A (captured copy)
add_b  out  L*WIDTH  adder operand B (captured copy)
add_rst  out  1  adder restart, active-high
add_finish  in  1  adder finish level
add_c  in  L*WIDTH  adder sum

Behaviour:
- Reset (rst=0, async): state IDLE; gnt=0, done=0, res=0, busy=0, err=0, add_a=add_b=0, add_rst=1; RR pointer=0 (requester 0 highest priority).
- FSM (all transitions on posedge ck):
  - IDLE: add_rst=1. If any req bit is set, pick the first set bit searching from pointer upward with wrap. Register gnt[w]=1; capture req_a[w]/req_b[w] into add_a/add_b; go LOAD. Otherwise stay.
  - LOAD: one cycle; add_rst=1, operands stable. The adder clears on this edge. Next state RUN; clear timeout counter.
  - RUN: add_rst=0; counter increments each cycle.
    - If add_finish=1: res<=add_c, go DONE.
    - Else, if counter reaches TIMEOUT-1: err<=1, res<=add_c, go DONE.
    - Finish has priority over timeout when both occur in the same cycle.
  - DONE: one cycle; done[w]=1, gnt[w] still 1; pointer<=(w+1) mod NREQ. Next: IDLE, gnt cleared.
- Latency: req sampled at edge T gives gnt at T+1 and add_rst low from T+2. The adder asserts finish L+2 cycles after its restart. done pulse is L+5 cycles after req sampling (L=4: 9 cycles). Back-to-back ops give one idle cycle between done and the next gnt.
- Operands are sampled only at grant; the requester may change req_a/req_b after gnt rises.
- req is level. A requester still asserting req after done is re-eligible, but only after the others because the pointer moved past it. Dropping req while granted does not abort the operation.
- Simultaneous requests: exactly one grant; gnt is always one-hot or zero.
- The operation is not cancellable except by rst. Reset mid-operation returns everything to reset values immediately and emits no done.
- err is cleared only by rst. Operations continue normally after err is set.
- No arithmetic in this block; res is add_c verbatim (base-MAX limbs, limb 0 least significant).

Test Plan:
- Single request: L=4, MAX=10000, req=3'b001, a={0,0,1,9999}, b={0,0,0,1} (limb3..0) → gnt=3'b001 one cycle after req; done[0] pulse 9 cycles after req sampling; res={0,0,2,0}; add_rst high in IDLE/LOAD only.
- Simultaneous requests: req=3'b111 held → grants in order 0,1,2,0; each done goes only to the granted index; no gnt overlap; one idle cycle between done and the next gnt.
- Operand capture: change req_a[1] one cycle after gnt[1] → res reflects the pre-grant operands.
- Timeout: add_finish tied 0, TIMEOUT=64 → err=1 and done pulse 64 RUN cycles after entering RUN; next request still completes correctly with err remaining 1.
- Reset mid-RUN: rst=0 asynchronously during RUN → outputs return to reset values without waiting for ck; no done; after release, req=3'b010 is served with the pointer back at 0 (requester 0 priority on the next tie).
- Finish and timeout same cycle: add_finish forced high at counter=TIMEOUT-1 → err stays 0, res=add_c.
